sd_route_ctl: RTL and testbench

//  Parametrised SD-SPI router between the core's single SPI master and one physical SD slot

---
 rtl/sd_route_ctl.sv | 159 +++++++++++++++
 tb/tb_sd_route_ctl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sd_route_ctl.sv
// SD-SPI router: steers the core's SPI master to the physical card or one of the
// virtual image slots, defers switches until the bus is idle, and drives reset/LEDs.
module sd_route_ctl #(
   parameter int NUM_SLOTS = 2,
   parameter int RST_PULSE = 10_000_000,
   parameter int ACT_HOLD  = 1_000_000
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic [NUM_SLOTS-1:0] img_mounted,
   input  logic [NUM_SLOTS-1:0] img_nz,
   input  logic                 spi_cs_n,
   input  logic                 spi_sck,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 phys_cs_n,
   output logic                 phys_sck,
   output logic                 phys_mosi,
   input  logic                 phys_miso,
   output logic [NUM_SLOTS-1:0] virt_cs_n,
   input  logic [NUM_SLOTS-1:0] virt_miso,
   output logic [2:0]           sel,
   output logic                 pending,
   output logic                 reset_img,
   output logic                 led_virt,
   output logic                 led_phys
);

   localparam int RW = $clog2(RST_PULSE + 1);
   localparam int AW = $clog2(ACT_HOLD + 1);

   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

   state_t        state_q;
   logic [2:0]    sel_q, sel_d, tgt_q, target, win_slot;
   logic          mount, win_nz;
   logic [RW-1:0] rst_cnt_q;
   logic          reset_img_q;
   logic [AW-1:0] act_cnt_q, act_cnt_d;
   logic          mosi_q, miso_q, toggle, act_d;
   logic          led_virt_q, led_phys_q;

   // Lowest mounted slot wins; an empty image ejects only the slot that is active or queued.
   always_comb begin
      mount    = 1'b0;
      win_slot = 3'd0;
      win_nz   = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (img_mounted[i]) begin
            mount    = 1'b1;
            win_slot = 3'(i + 1);
            win_nz   = img_nz[i];
         end
      end
      if (win_nz)
         target = win_slot;
      else if (sel_q == win_slot || (state_q == PEND && tgt_q == win_slot))
         target = 3'd0;
      else
         target = sel_q;
   end

   always_comb begin
      sel_d = sel_q;
      if (spi_cs_n) begin
         if (mount)
            sel_d = target;
         else if (state_q == PEND)
            sel_d = tgt_q;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         tgt_q   <= 3'd0;
      end else begin
         sel_q <= sel_d;
         case (state_q)
            IDLE: begin
               if (mount && !spi_cs_n) begin
                  tgt_q   <= target;
                  state_q <= PEND;
               end
            end
            PEND: begin
               if (spi_cs_n)
                  state_q <= IDLE;
               else if (mount)
                  tgt_q <= target;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rst_cnt_q   <= '0;
         reset_img_q <= 1'b0;
      end else if (mount) begin
         rst_cnt_q   <= RW'(RST_PULSE);
         reset_img_q <= 1'b1;
      end else if (rst_cnt_q != '0) begin
         rst_cnt_q   <= rst_cnt_q - 1'b1;
         reset_img_q <= (rst_cnt_q != RW'(1));
      end
   end

   always_comb begin
      phys_cs_n = (sel_q != 3'd0) | spi_cs_n;
      phys_sck  = spi_sck & ~phys_cs_n;
      phys_mosi = spi_mosi & ~phys_cs_n;
      spi_miso  = 1'b1;
      if (sel_q == 3'd0)
         spi_miso = phys_miso;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         virt_cs_n[k] = (sel_q != 3'(k + 1)) | spi_cs_n;
         if (sel_q == 3'(k + 1))
            spi_miso = virt_miso[k];
      end
   end

   // LEDs use the next counter and next selection so they light and move on the same edge.
   always_comb begin
      toggle = (spi_mosi ^ mosi_q) | (spi_miso ^ miso_q);
      if (toggle)
         act_cnt_d = '0;
      else if (act_cnt_q < AW'(ACT_HOLD))
         act_cnt_d = act_cnt_q + 1'b1;
      else
         act_cnt_d = act_cnt_q;
      act_d = act_cnt_d < AW'(ACT_HOLD);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mosi_q     <= 1'b0;
         miso_q     <= 1'b0;
         act_cnt_q  <= AW'(ACT_HOLD);
         led_virt_q <= 1'b0;
         led_phys_q <= 1'b0;
      end else begin
         mosi_q     <= spi_mosi;
         miso_q     <= spi_miso;
         act_cnt_q  <= act_cnt_d;
         led_virt_q <= act_d & (sel_d != 3'd0);
         led_phys_q <= act_d & (sel_d == 3'd0);
      end
   end

   assign sel       = sel_q;
   assign pending   = (state_q == PEND);
   assign reset_img = reset_img_q;
   assign led_virt  = led_virt_q;
   assign led_phys  = led_phys_q;

endmodule

// File: tb/tb_sd_route_ctl.sv
// Directed bench for sd_route_ctl with a short reset pulse and activity hold.
module tb_sd_route_ctl;

   localparam int NS = 2;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic [NS-1:0] img_mounted = '0;
   logic [NS-1:0] img_nz = '0;
   logic          spi_cs_n = 1'b1;
   logic          spi_sck = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          spi_miso;
   logic          phys_cs_n, phys_sck, phys_mosi;
   logic          phys_miso = 1'b0;
   logic [NS-1:0] virt_cs_n;
   logic [NS-1:0] virt_miso = '0;
   logic [2:0]    sel;
   logic          pending, reset_img, led_virt, led_phys;

   int n_checks = 0;
   int n_fail   = 0;

   sd_route_ctl #(.NUM_SLOTS(NS), .RST_PULSE(8), .ACT_HOLD(4)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .img_mounted(img_mounted), .img_nz(img_nz),
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .phys_cs_n(phys_cs_n), .phys_sck(phys_sck), .phys_mosi(phys_mosi), .phys_miso(phys_miso),
      .virt_cs_n(virt_cs_n), .virt_miso(virt_miso),
      .sel(sel), .pending(pending), .reset_img(reset_img),
      .led_virt(led_virt), .led_phys(led_phys)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel); end
      n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", pending); end
      n_checks++; if (reset_img !== 1'b0) begin n_fail++; $display("FAIL reset_img got=%b exp=0", reset_img); end
      n_checks++; if ({led_virt, led_phys} !== 2'b00) begin n_fail++; $display("FAIL reset_leds got=%b%b exp=00", led_virt, led_phys); end
      reset = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_mount_idle();
      int hi;
      img_mounted = 2'b01; img_nz = 2'b01; spi_cs_n = 1'b1;
      tick();
      img_mounted = 2'b00;
      n_checks++; if (sel !== 3'd1) begin n_fail++; $display("FAIL mount_sel got=%0d exp=1", sel); end
      n_checks++; if (reset_img !== 1'b1) begin n_fail++; $display("FAIL mount_rimg got=%b exp=1", reset_img); end
      spi_cs_n = 1'b0; #1;
      n_checks++; if ({phys_cs_n, virt_cs_n} !== 3'b110) begin n_fail++; $display("FAIL cs_low_route got=%b exp=110", {phys_cs_n, virt_cs_n}); end
      spi_cs_n = 1'b1; #1;
      n_checks++; if (virt_cs_n !== 2'b11) begin n_fail++; $display("FAIL cs_high_route got=%b exp=11", virt_cs_n); end
      hi = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (reset_img) hi++;
         else break;
      end
      n_checks++; if (hi !== 8) begin n_fail++; $display("FAIL pulse_len got=%0d exp=8", hi); end
   endtask

   task automatic test_pending();
      spi_cs_n = 1'b0;
      img_mounted = 2'b10; img_nz = 2'b10;
      tick();
      img_mounted = 2'b00;
      n_checks++; if ({pending, sel} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL pend_set got=%b/%0d exp=1/1", pending, sel); end
      tick();
      n_checks++; if ({pending, sel} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL pend_hold got=%b/%0d exp=1/1", pending, sel); end
      spi_cs_n = 1'b1;
      tick();
      n_checks++; if ({pending, sel} !== {1'b0, 3'd2}) begin n_fail++; $display("FAIL pend_release got=%b/%0d exp=0/2", pending, sel); end
      virt_miso = 2'b10; #1;
      n_checks++; if (spi_miso !== 1'b1) begin n_fail++; $display("FAIL miso_slot2_hi got=%b exp=1", spi_miso); end
      virt_miso = 2'b01; #1;
      n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL miso_slot2_lo got=%b exp=0", spi_miso); end
      virt_miso = 2'b00;
   endtask

   task automatic test_eject();
      img_mounted = 2'b10; img_nz = 2'b00;
      tick();
      img_mounted = 2'b00;
      n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL eject_sel got=%0d exp=0", sel); end
      spi_cs_n = 1'b0; spi_sck = 1'b1; spi_mosi = 1'b1; phys_miso = 1'b1; #1;
      n_checks++; if ({phys_cs_n, phys_sck, phys_mosi, virt_cs_n} !== 5'b01111) begin n_fail++; $display("FAIL phys_route got=%b exp=01111", {phys_cs_n, phys_sck, phys_mosi, virt_cs_n}); end
      n_checks++; if (spi_miso !== 1'b1) begin n_fail++; $display("FAIL phys_miso got=%b exp=1", spi_miso); end
      spi_cs_n = 1'b1; #1;
      n_checks++; if ({phys_cs_n, phys_sck, phys_mosi} !== 3'b100) begin n_fail++; $display("FAIL phys_gated got=%b exp=100", {phys_cs_n, phys_sck, phys_mosi}); end
      spi_sck = 1'b0; spi_mosi = 1'b0; phys_miso = 1'b0;
      tick();
      img_mounted = 2'b10; img_nz = 2'b00;
      tick();
      img_mounted = 2'b00;
      n_checks++; if ({sel, reset_img} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL eject_other got=%0d/%b exp=0/1", sel, reset_img); end
   endtask

   task automatic test_retrigger();
      int hi;
      bit early_ok;
      for (int k = 0; k < 20 && reset_img; k++) tick();
      n_checks++; if (reset_img !== 1'b0) begin n_fail++; $display("FAIL drain_timeout got=%b exp=0", reset_img); end
      img_mounted = 2'b11; img_nz = 2'b11;
      tick();
      img_mounted = 2'b00;
      n_checks++; if ({sel, reset_img} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL dual_mount got=%0d/%b exp=1/1", sel, reset_img); end
      early_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (reset_img !== 1'b1) early_ok = 1'b0;
      end
      n_checks++; if (early_ok !== 1'b1) begin n_fail++; $display("FAIL pulse_early got=%b exp=1", early_ok); end
      img_mounted = 2'b01; img_nz = 2'b01;
      tick();
      img_mounted = 2'b00;
      hi = (reset_img === 1'b1) ? 1 : 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (reset_img) hi++;
         else break;
      end
      n_checks++; if (hi !== 8) begin n_fail++; $display("FAIL retrig_len got=%0d exp=8", hi); end
   endtask

   task automatic test_activity();
      bit held;
      repeat (6) tick();
      n_checks++; if ({led_virt, led_phys} !== 2'b00) begin n_fail++; $display("FAIL idle_leds got=%b%b exp=00", led_virt, led_phys); end
      spi_mosi = 1'b1;
      tick();
      n_checks++; if ({led_virt, led_phys} !== 2'b10) begin n_fail++; $display("FAIL led_on got=%b%b exp=10", led_virt, led_phys); end
      held = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if ({led_virt, led_phys} !== 2'b10) held = 1'b0;
      end
      n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL led_hold got=%b exp=1", held); end
      tick();
      n_checks++; if ({led_virt, led_phys} !== 2'b00) begin n_fail++; $display("FAIL led_off got=%b%b exp=00", led_virt, led_phys); end
      spi_mosi = 1'b0;
      tick();
      img_mounted = 2'b01; img_nz = 2'b00;
      tick();
      img_mounted = 2'b00;
      n_checks++; if ({sel, led_virt, led_phys} !== {3'd0, 2'b01}) begin n_fail++; $display("FAIL led_move got=%0d/%b%b exp=0/01", sel, led_virt, led_phys); end
   endtask

   task automatic test_async_reset();
      spi_cs_n = 1'b0;
      img_mounted = 2'b10; img_nz = 2'b10;
      tick();
      img_mounted = 2'b00;
      spi_mosi = 1'b1;
      tick();
      n_checks++; if ({pending, reset_img, led_phys} !== 3'b111) begin n_fail++; $display("FAIL pre_reset got=%b exp=111", {pending, reset_img, led_phys}); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if ({sel, pending, reset_img, led_virt, led_phys} !== 7'd0) begin n_fail++; $display("FAIL async_reset got=%b exp=0000000", {sel, pending, reset_img, led_virt, led_phys}); end
      tick();
      reset = 1'b0;
      spi_cs_n = 1'b1;
      tick();
      n_checks++; if ({sel, pending} !== 4'd0) begin n_fail++; $display("FAIL target_lost got=%0d/%b exp=0/0", sel, pending); end
   endtask

   initial begin
      test_reset();
      test_mount_idle();
      test_pending();
      test_eject();
      test_retrigger();
      test_activity();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
